// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: helpers shared by seq_capture_checker and its pipeline.
package seq_chk_pkg;

    localparam int SAT_MAX_W = 64;

    function automatic bit delay_ok(input int delay);
        return delay >= 1;
    endfunction

    // Counters up to SAT_MAX_W bits wide share this; w is the counter width.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int w);
        logic [SAT_MAX_W-1:0] top;
        top = (w >= SAT_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/seq_chk_pipe.sv
// seq_chk_pipe: flushable valid/data shift register of depth DEPTH.
module seq_chk_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [DEPTH-1:0] vld_o
);

    logic [DEPTH-1:0] vld_d, vld_q;
    logic [WIDTH-1:0] cap_d [DEPTH];
    logic [WIDTH-1:0] cap_q [DEPTH];

    always_comb begin
        vld_d = flush_i ? '0 : DEPTH'({vld_q, in_vld_i});
        cap_d[0] = in_data_i;
        for (int k = 1; k < DEPTH; k++) cap_d[k] = cap_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cap_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            cap_q <= cap_d;
        end
    end

    assign out_vld_o  = vld_q[DEPTH-1];
    assign out_data_o = cap_q[DEPTH-1];
    assign vld_o      = vld_q;

endmodule

// File: rtl/seq_capture_checker.sv
// seq_capture_checker: RTL form of (start, cap = data) ##DELAY (check == cap + OFFSET) under MASK.
// Define SEQ_CHK_SVA_EN to also build the equivalent concurrent assertion and a start cover.
module seq_capture_checker
    import seq_chk_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               DELAY  = 1,
    parameter int               OFFSET = 0,
    parameter logic [WIDTH-1:0] MASK   = '1,
    parameter int               CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disable_i,
    input  logic                       start_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [WIDTH-1:0]           check_i,
    input  logic                       clear_i,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [CNT_W-1:0]           pass_cnt_o,
    output logic [CNT_W-1:0]           fail_cnt_o,
    output logic [$clog2(DELAY+1)-1:0] inflight_o,
    output logic                       first_fail_vld_o,
    output logic [WIDTH-1:0]           first_fail_exp_o,
    output logic [WIDTH-1:0]           first_fail_got_o
);

    localparam int IW = $clog2(DELAY + 1);

    if (!delay_ok(DELAY)) begin : g_bad_delay
        $error("seq_capture_checker: DELAY must be at least 1");
    end

    logic             eval_vld, hit, ok, latch;
    logic [WIDTH-1:0] eval_cap, exp_val;
    logic [DELAY-1:0] vld_vec;
    logic             pass_d, pass_q, fail_d, fail_q, ff_vld_d, ff_vld_q;
    logic [CNT_W-1:0] pass_cnt_d, pass_cnt_q, fail_cnt_d, fail_cnt_q;
    logic [WIDTH-1:0] ff_exp_d, ff_exp_q, ff_got_d, ff_got_q;

    seq_chk_pipe #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (disable_i),
        .in_vld_i   (start_i),
        .in_data_i  (data_i),
        .out_vld_o  (eval_vld),
        .out_data_o (eval_cap),
        .vld_o      (vld_vec)
    );

    // The oldest stage holds the attempt whose DELAY cycles elapse at this edge.
    always_comb begin
        exp_val    = eval_cap + WIDTH'(OFFSET);
        ok         = ((check_i ^ exp_val) & MASK) == '0;
        hit        = eval_vld & ~disable_i;
        pass_d     = hit & ok;
        fail_d     = hit & ~ok;
        latch      = fail_d & ~ff_vld_q & ~clear_i;
        pass_cnt_d = clear_i ? '0 : pass_d ? CNT_W'(sat_inc(64'(pass_cnt_q), CNT_W)) : pass_cnt_q;
        fail_cnt_d = clear_i ? '0 : fail_d ? CNT_W'(sat_inc(64'(fail_cnt_q), CNT_W)) : fail_cnt_q;
        ff_vld_d   = ~clear_i & (ff_vld_q | fail_d);
        ff_exp_d   = latch ? exp_val : ff_exp_q;
        ff_got_d   = latch ? check_i : ff_got_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ff_vld_q   <= 1'b0;
            ff_exp_q   <= '0;
            ff_got_q   <= '0;
        end else begin
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ff_vld_q   <= ff_vld_d;
            ff_exp_q   <= ff_exp_d;
            ff_got_q   <= ff_got_d;
        end
    end

    assign pass_o           = pass_q;
    assign fail_o           = fail_q;
    assign pass_cnt_o       = pass_cnt_q;
    assign fail_cnt_o       = fail_cnt_q;
    assign inflight_o       = IW'($countones(vld_vec));
    assign first_fail_vld_o = ff_vld_q;
    assign first_fail_exp_o = ff_exp_q;
    assign first_fail_got_o = ff_got_q;

`ifdef SEQ_CHK_SVA_EN
    sequence s_check;
        logic [WIDTH-1:0] cap;
        (start_i, cap = data_i) ##DELAY (((check_i ^ (cap + WIDTH'(OFFSET))) & MASK) == '0);
    endsequence

    a_seq_check: assert property (@(posedge clk) disable iff (!rst_n || disable_i) start_i |-> s_check);
    c_start: cover property (@(posedge clk) disable iff (!rst_n || disable_i) start_i);
`else
    // Synthesis build: the checker is pure RTL.
`endif

endmodule

// File: doc/seq_capture_checker.md
Name: seq_capture_checker

Overview:
Synthesisable hardware equivalent of a sequence with a local variable: `(start, captured = data) ##DELAY (check == f(captured))`. Each start launches an attempt that carries its own captured value through a DELAY-stage pipeline, so up to DELAY attempts overlap. The block reports pass/fail pulses, saturating counters and the first failing pair. It sits beside the design under check in assertion-to-RTL regression tests.

Parameters:
WIDTH, 8, width of captured and checked data.
DELAY, 1, cycles from capture to check (the `##N`); must be at least 1, and 0 is an elaboration error.
OFFSET, 0, expected value is `(captured + OFFSET)` mod 2^WIDTH.
MASK, all ones (WIDTH bits), bits compared; bits cleared in MASK are ignored.
CNT_W, 16, width of the pass and fail counters.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
disable_i  in  1  disable-iff; flushes in-flight attempts.
start_i  in  1  start an attempt this cycle.
data_i  in  WIDTH  value captured into the attempt's local variable.
check_i  in  WIDTH  value observed DELAY cycles later.
clear_i  in  1  synchronous clear of counters and first-failure record.
pass_o  out  1  registered pulse: an attempt passed.
fail_o  out  1  registered pulse: an attempt failed.
pass_cnt_o  out  CNT_W  saturating pass count.
fail_cnt_o  out  CNT_W  saturating fail count.
inflight_o  out  $clog2(DELAY+1)  live attempts in the pipeline.
first_fail_vld_o  out  1  a failure has been recorded since reset or clear.
first_fail_exp_o  out  WIDTH  expected value of the first failure.
first_fail_got_o  out  WIDTH  check_i value at the first failure.

Behaviour:
- Reset: all outputs 0, pipeline empty. Reset is asserted asynchronously and may land mid-attempt; every in-flight attempt is dropped and none reports afterwards.
- Pipeline: DELAY stages, each holding {vld, cap}. Each posedge, stage k+1 takes stage k.
  - Stage 0 takes vld = start_i & ~disable_i and cap = data_i.
- Evaluation: an attempt started at edge t evaluates at edge t+DELAY using check_i sampled at that edge.
  - ok = ((check_i ^ (cap + OFFSET)) & MASK) == 0, with the addition wrapping at WIDTH bits.
  - pass_o or fail_o is high in the cycle after edge t+DELAY. It is a single-cycle pulse and the two are never high together.
- Back-to-back starts are all independent. Each attempt keeps its own cap and produces one pulse per cycle, in start order.
- disable_i high at an edge:
  - clears every stage's vld, so no attempt evaluates that edge;
  - suppresses that edge's start;
  - forces pass_o and fail_o low next cycle.
  - Counters and the first-failure record hold their values.
- inflight_o = number of set vld bits after the edge; its maximum is DELAY.
- Counters increment on their pulse and saturate at 2^CNT_W-1 with no wrap.
- clear_i at an edge: zeroes both counters and first_fail_vld_o. Clear wins over a simultaneous increment; that event is not counted. pass_o and fail_o are unaffected by clear_i.
- First failure: on the first fail while first_fail_vld_o=0, latch the expected value (cap+OFFSET) and check_i, and set first_fail_vld_o. Later failures do not overwrite it.

Optional Feature:
SEQ_CHK_SVA_EN defined:
- The module also contains a concurrent property. It is clocked on `posedge clk`, has `disable iff (!rst_n || disable_i)`, and declares a sequence local variable `cap` matching the behaviour above.
- The property has an assert, plus a cover for `start_i`.
- An assertion failure must occur at the same edge as the one whose result drives fail_o high.

Undefined: pure RTL; no SVA constructs are present, so synthesis flows accept the file.

Decomposition:
- Package seq_chk_pkg: DELAY-validity check function, and a saturating-increment function parametrised on CNT_W.
- Sub-module seq_chk_pipe: a flushable valid/data shift register of depth DELAY and width WIDTH. Its outputs are the last stage and the vld vector, which is used for inflight_o.

Test Plan:
- DELAY=1, OFFSET=0: start with data 0x05, check_i=0x05 one edge later -> pass_o=1 next cycle, pass_cnt_o=1, fail_cnt_o=0.
- DELAY=3, OFFSET=1: starts on 3 consecutive edges with data 0x10, 0x20, 0xFF; check_i 0x11, 0x00, 0x00 three edges after each -> pass, fail, pass (0xFF+1 wraps to 0x00); first_fail_exp_o=0x21, first_fail_got_o=0x00; inflight_o peaks at 3.
- DELAY=4: 2 attempts in flight, then disable_i high for one edge -> no pulses for those attempts; inflight_o=0; counters unchanged.
- CNT_W=2: 5 consecutive failing attempts -> fail_cnt_o stops at 3. Then clear_i coincides with a fail -> fail_cnt_o=0 and first_fail_vld_o=0, while fail_o still pulses.
- MASK=0x0F: data 0xA3, check_i 0x53 -> pass, because the upper nibble is ignored.
- Drop rst_n asynchronously with 2 attempts in flight, then release -> all outputs 0 immediately; no pulses for the dropped attempts.
